// File: rtl/rst_seq_watchdog.sv
// Reset sequencer and run monitor: async-assert/sync-release core reset plus
// a cycle-counting watchdog that latches pass, error (with source) or timeout.
module rst_seq_watchdog #(
  parameter int SYNC_STAGES = 2,
  parameter int RST_CYCLES  = 2,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 100004,
  parameter int NUM_ERR     = 1,
  parameter int SRC_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_ERR-1:0] err,
  input  logic               halt,
  output logic               core_rst,
  output logic               running,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               done,
  output logic               pass,
  output logic               err_seen,
  output logic [SRC_W-1:0]   err_src,
  output logic               timeout
);

  // state   | meaning
  // SYNC    | release synchroniser filling with ones
  // HOLD    | core_rst held for RST_CYCLES more edges
  // RUN     | core running, counting cycles, watching err/halt/limit
  // PASS    | terminal: halted normally
  // ERROR   | terminal: an err input fired
  // TIMEOUT | terminal: CYCLE_LIMIT reached
  typedef enum logic [2:0] {
    S_SYNC, S_HOLD, S_RUN, S_PASS, S_ERROR, S_TIMEOUT
  } state_t;

  localparam int HOLD_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [SRC_W-1:0]       src_q, src_d, low_idx;
  logic                   core_rst_q, core_rst_d;

  // Lowest-index set error bit wins; scan downwards so the last hit is the lowest.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_ERR - 1; i >= 0; i--) begin
      if (err[i]) low_idx = SRC_W'(i);
    end
  end

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    src_d      = src_q;
    core_rst_d = core_rst_q;
    unique case (state_q)
      S_SYNC: begin
        if (sync_d[SYNC_STAGES-1]) begin
          state_d = S_HOLD;
          hold_d  = '0;
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_W'(RST_CYCLES - 1)) begin
          state_d    = S_RUN;
          core_rst_d = 1'b0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (|err) begin
          state_d = S_ERROR;
          src_d   = low_idx;
        end else if (halt) begin
          state_d = S_PASS;
        end else if (cnt_q == CNT_W'(CYCLE_LIMIT - 1)) begin
          state_d = S_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_SYNC;
      sync_q     <= '0;
      hold_q     <= '0;
      cnt_q      <= '0;
      src_q      <= '0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      src_q      <= src_d;
      core_rst_q <= core_rst_d;
    end
  end

  // Status decodes straight from the state register, so the three outcomes are exclusive.
  assign core_rst    = core_rst_q;
  assign running     = (state_q == S_RUN);
  assign pass        = (state_q == S_PASS);
  assign err_seen    = (state_q == S_ERROR);
  assign timeout     = (state_q == S_TIMEOUT);
  assign done        = pass | err_seen | timeout;
  assign err_src     = err_seen ? src_q : '0;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_rst_seq_watchdog.sv
// Directed bench for rst_seq_watchdog: expected status vectors are queued as
// stimulus is applied and popped when the DUT output is sampled.
module tb_rst_seq_watchdog;

  localparam int CNT_W = 5;
  localparam int NUM_ERR = 4;
  localparam int SRC_W = 4;
  localparam int LIMIT = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_ERR-1:0] err;
  logic               halt;
  logic               core_rst, running, done, pass, err_seen, timeout;
  logic [CNT_W-1:0]   cycle_count;
  logic [SRC_W-1:0]   err_src;

  int compared = 0;
  int mismatched = 0;

  logic [14:0] exp_q[$];
  string       tag_q[$];

  rst_seq_watchdog #(
    .SYNC_STAGES(2), .RST_CYCLES(2), .CNT_W(CNT_W),
    .CYCLE_LIMIT(LIMIT), .NUM_ERR(NUM_ERR), .SRC_W(SRC_W)
  ) dut (
    .clk(clk), .rst(rst), .err(err), .halt(halt),
    .core_rst(core_rst), .running(running), .cycle_count(cycle_count),
    .done(done), .pass(pass), .err_seen(err_seen), .err_src(err_src),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // {core_rst, running, done, pass, err_seen, timeout, err_src, cycle_count}
  function automatic logic [14:0] pk(input logic cr, input logic rn, input logic dn,
                                     input logic ps, input logic es, input logic to,
                                     input logic [3:0] src, input int cnt);
    return {cr, rn, dn, ps, es, to, src, 5'(cnt)};
  endfunction

  localparam logic [14:0] RST_V = {1'b1, 14'b0};

  function automatic logic [14:0] run_v(input int cnt);
    return pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, cnt);
  endfunction

  function automatic logic [14:0] hold_v();
    return pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 0);
  endfunction

  task automatic push(input string tag, input logic [14:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare();
    logic [14:0] obs, e;
    string t;
    obs = {core_rst, running, done, pass, err_seen, timeout, err_src, cycle_count};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    compared++;
    assert (obs === e) else begin
      mismatched++;
      $display("FAIL %s: observed %b expected %b", t, obs, e);
      $error("check %s observed %b expected %b", t, obs, e);
    end
  endtask

  task automatic tick(input string tag, input logic [14:0] e);
    push(tag, e);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic now(input string tag, input logic [14:0] e);
    push(tag, e);
    #1;
    compare();
  endtask

  // Release from reset (sampled just after a posedge) and walk to RUN with cnt=0.
  task automatic release_to_run(input string tag);
    rst = 1'b1;
    tick({tag, "_e1"}, hold_v());
    tick({tag, "_e2"}, hold_v());
    tick({tag, "_e3"}, hold_v());
    tick({tag, "_e4"}, run_v(0));
  endtask

  initial begin
    rst = 1'b1; err = '0; halt = 1'b0;
    #2 rst = 1'b0;
    now("reset_async", RST_V);
    for (int i = 0; i < 3; i++) tick("reset_hold", RST_V);

    // Release timing and pass
    release_to_run("release");
    for (int i = 1; i <= 10; i++) tick("run_count", run_v(i));
    halt = 1'b1;
    tick("pass", pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 11));
    halt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      halt = 1'($urandom_range(0, 1));
      err  = 4'($urandom_range(0, 15));
      tick("pass_sticky", pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 11));
    end
    halt = 1'b0; err = '0;

    // Short release pulse must not drop core_rst
    #2 rst = 1'b0;
    now("reset_from_pass", RST_V);
    rst = 1'b1;
    tick("short_rel", RST_V);
    rst = 1'b0;
    now("short_rel_low", RST_V);
    tick("short_rel_after", RST_V);

    // Error during HOLD ignored, then error beats halt in RUN
    rst = 1'b1;
    tick("early_e1", hold_v());
    tick("early_e2", hold_v());
    err = 4'b0001;
    tick("early_e3_err", hold_v());
    err = '0;
    tick("early_e4", run_v(0));
    tick("early_run1", run_v(1));
    tick("early_run2", run_v(2));
    err = 4'b1010; halt = 1'b1;
    tick("err_prio", pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 3));
    err = 4'b0001; halt = 1'b0;
    tick("err_sticky1", pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 3));
    err = 4'b1000;
    tick("err_sticky2", pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 3));
    err = '0;

    // Timeout at CYCLE_LIMIT
    #2 rst = 1'b0;
    now("reset_from_err", RST_V);
    @(posedge clk); #1;
    release_to_run("to");
    for (int i = 1; i < LIMIT; i++) tick("to_count", run_v(i));
    tick("timeout", pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, LIMIT));
    err = 4'b0100; halt = 1'b1;
    for (int i = 0; i < 3; i++)
      tick("to_sticky", pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, LIMIT));
    err = '0; halt = 1'b0;

    // Mid-run asynchronous reset, then a full restart
    #2 rst = 1'b0;
    now("reset_from_to", RST_V);
    @(posedge clk); #1;
    release_to_run("mid");
    for (int i = 1; i <= 7; i++) tick("mid_count", run_v(i));
    #2 rst = 1'b0;
    now("mid_async", RST_V);
    @(posedge clk); #1;
    now("mid_held", RST_V);
    release_to_run("restart");
    tick("restart_run1", run_v(1));
    tick("restart_run2", run_v(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rst_seq_watchdog.md
Name: rst_seq_watchdog

Overview:
Parametrised reset sequencer and run monitor for the processor top level and testbenches. It takes the board/bench reset and produces a core reset that asserts asynchronously and deasserts synchronously, after a configurable hold. While the core runs, it counts cycles and watches a vector of error sources and a halt flag. It reports pass, error (with the source index) or timeout through sticky status outputs, so bench code only has to poll `done`.

Parameters:
SYNC_STAGES, 2, flops in the reset-release synchroniser (min 2)
RST_CYCLES, 2, extra clk cycles core_rst stays high after synchroniser release (min 1)
CNT_W, 32, cycle counter width
CYCLE_LIMIT, 100004, RUN cycles before timeout; must be < 2^CNT_W - 1
NUM_ERR, 1, number of error inputs (1..16)
SRC_W, 4, width of err_src

Ports:
clk  input  1  system clock, all flops on rising edge
rst  input  1  reset; asynchronous assert, active-low
err  input  NUM_ERR  per-source error flags, sampled at posedge
halt  input  1  core halted normally, sampled at posedge
core_rst  output  1  active-high reset to core; async assert, sync deassert
running  output  1  state == RUN
cycle_count  output  CNT_W  RUN cycles elapsed, saturating
done  output  1  terminal state reached (any of PASS/ERROR/TIMEOUT)
pass  output  1  terminated by halt
err_seen  output  1  terminated by error
err_src  output  SRC_W  index of lowest set err bit at termination
timeout  output  1  terminated by CYCLE_LIMIT

Behaviour:
- rst low, at any time including mid-run: every flop clears immediately and asynchronously, without waiting for clk.
  - core_rst=1; all other outputs 0; cycle_count=0; state=SYNC.
- States: SYNC, HOLD, RUN, PASS, ERROR, TIMEOUT.
- SYNC:
  - Synchroniser shifts a 1 in each posedge while rst high.
  - When the last stage is 1, go to HOLD with hold counter=0.
- HOLD:
  - Hold counter increments each posedge.
  - At RST_CYCLES go to RUN and clear core_rst in the same edge.
  - With the defaults, core_rst falls on the 4th posedge after rst rises.
- RUN:
  - cycle_count increments each posedge and saturates, never wraps.
  - Evaluation priority at each posedge in RUN: err, then halt, then limit.
    - Any err bit set: go to ERROR, err_seen=1, err_src = lowest set index (zero-extended).
    - Else halt=1: go to PASS, pass=1.
    - Else cycle_count == CYCLE_LIMIT-1 (so this edge makes it CYCLE_LIMIT): go to TIMEOUT, timeout=1, cycle_count=CYCLE_LIMIT.
  - On an err or halt edge, cycle_count still increments on that edge.
- PASS/ERROR/TIMEOUT:
  - Terminal until rst is asserted.
  - done=1, cycle_count frozen, status bits sticky, core_rst stays 0 (core is not reset), err and halt ignored.
- err and halt are ignored in SYNC and HOLD. An error pulse there must not latch.
- rst deasserting for less than SYNC_STAGES edges and then reasserting: core_rst never drops.
- Exactly one of pass/err_seen/timeout is ever 1, and only when done=1.
- Fully synthesizable: no $display or $finish. Bench wrappers act on done.

Test Plan:
- Release: rst=0 for 3 cycles, then 1; defaults → core_rst=1 through posedge 3 after release, 0 after posedge 4; running=1 same edge; cycle_count=0 then increments by 1 per edge.
- Pass: run 10 cycles, pulse halt one cycle → pass=1, done=1, cycle_count=11, stays 11 for 20 more cycles while halt and err toggle.
- Error priority: NUM_ERR=4; in RUN drive err=4'b1010 and halt=1 on the same edge → err_seen=1, err_src=1, pass=0; later err changes have no effect.
- Timeout: CYCLE_LIMIT=16, CNT_W=5, no halt → timeout=1 and cycle_count=16 on the 16th RUN edge; remains 16; err asserted afterwards ignored.
- Ignored-early error: err=1 during HOLD, cleared before RUN → err_seen stays 0 and run proceeds normally.
- Mid-run reset: at cycle_count=7 pull rst low between edges → core_rst=1 and all status 0 before the next clk edge. Release → full SYNC/HOLD sequence repeats; cycle_count restarts at 0.
